// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word memory.
// Port 0 is the CPU data path and port 1 is the loader/debug port.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   req*, we*, lock*         per-port request, write enable, lock hint
//   addr*, wdata*            per-port word address and write data
//   gnt*                     combinational grant; access completes at the edge
//   rvalid*, rdata*          registered read-valid; rdata follows mem_dout
//   mem_addr, mem_din,
//   mem_we, mem_dout         single-port synchronous memory interface
module mem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          last_grant_q, last_grant_d;
  logic          locked_q, locked_d;
  logic          lock_owner_q, lock_owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;

  logic sel;
  logic any_gnt;
  logic lock_hold;
  logic we_g;
  logic lock_g;

  // The lock is honoured only while its budget of consecutive
  // grants under contention is not used up.
  assign lock_hold = locked_q && (lock_cnt_q < CNT_MAX);

  // sel names the winning port; it stays 0 when idle or in reset
  // so the memory mux defaults to port 0.
  always_comb begin
    sel  = 1'b0;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        sel = lock_hold ? lock_owner_q : ~last_grant_q;
      end else begin
        sel = req1;
      end
      gnt0 = req0 & ~sel;
      gnt1 = req1 & sel;
    end
  end

  assign any_gnt = gnt0 | gnt1;
  assign we_g    = sel ? we1 : we0;
  assign lock_g  = sel ? lock1 : lock0;

  assign mem_addr = sel ? addr1 : addr0;
  assign mem_din  = sel ? wdata1 : wdata0;
  assign mem_we   = we_g & any_gnt;

  assign rdata0  = mem_dout;
  assign rdata1  = mem_dout;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

  always_comb begin
    last_grant_d = last_grant_q;
    locked_d     = locked_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    if (any_gnt) begin
      last_grant_d = sel;
      if (lock_g) begin
        // A repeat grant to the current owner extends its run;
        // any other grant starts a fresh run for the new owner.
        if (locked_q && (lock_owner_q == sel)) begin
          if (lock_cnt_q == CNT_MAX) begin
            lock_cnt_d = CNT_MAX;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_ONE;
          end
        end else begin
          lock_cnt_d = CNT_ONE;
        end
        locked_d     = 1'b1;
        lock_owner_d = sel;
      end else begin
        locked_d   = 1'b0;
        lock_cnt_d = '0;
      end
    end else begin
      locked_d   = 1'b0;
      lock_cnt_d = '0;
    end
  end

  assign rvalid0_d = gnt0 & ~we0;
  assign rvalid1_d = gnt1 & ~we1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      locked_q     <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed
// sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LOCK_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout)
  );

  // Synchronous single-port memory
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= mem_din;
    mem_dout <= mem_arr[mem_addr];
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level reference: who won, whose run of locked grants
  // is in progress and how long it is, plus a shadow of the memory.
  int            m_last;
  bit            m_lk;
  int            m_owner;
  int            m_run;
  int unsigned   smem [1<<AW];
  bit            exp_rv0, exp_rv1;
  logic [DW-1:0] exp_rd;
  int            last_w;
  logic          g0_s, g1_s;

  function automatic void model_reset();
    m_last = 1; m_lk = 0; m_owner = 0; m_run = 0;
    exp_rv0 = 0; exp_rv1 = 0;
  endfunction

  function automatic int winner();
    if (!req0 && !req1) return -1;
    if (req0 && !req1) return 0;
    if (req1 && !req0) return 1;
    if (m_lk && m_run < LOCK_MAX) return m_owner;
    return 1 - m_last;
  endfunction

  // One clock: check at the falling edge, then advance the model
  // across the rising edge with the inputs that were applied.
  task automatic tick();
    int w;
    bit wg, lg;
    logic [AW-1:0] ag;
    logic [DW-1:0] dg;
    @(negedge clk);
    w = winner();
    last_w = w;
    g0_s = gnt0;
    g1_s = gnt1;
    chk("gnt0", {31'd0, gnt0}, {31'd0, w == 0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, w == 1});
    chk("rvalid0", {31'd0, rvalid0}, {31'd0, exp_rv0});
    chk("rvalid1", {31'd0, rvalid1}, {31'd0, exp_rv1});
    if (exp_rv0) chk("rdata0", rdata0, exp_rd);
    if (exp_rv1) chk("rdata1", rdata1, exp_rd);
    wg = (w == 1) ? we1 : we0;
    lg = (w == 1) ? lock1 : lock0;
    ag = (w == 1) ? addr1 : addr0;
    dg = (w == 1) ? wdata1 : wdata0;
    chk("mem_we", {31'd0, mem_we}, {31'd0, (w >= 0) && wg});
    if (w >= 0) chk("mem_addr", {22'd0, mem_addr}, {22'd0, ag});
    if (w >= 0 && wg) chk("mem_din", mem_din, dg);
    @(posedge clk);
    exp_rv0 = (w == 0) && !wg;
    exp_rv1 = (w == 1) && !wg;
    if (w >= 0) begin
      if (wg) smem[ag] = dg;
      else exp_rd = smem[ag];
      if (lg) begin
        if (m_lk && m_owner == w) m_run = (m_run < LOCK_MAX) ? m_run + 1 : LOCK_MAX;
        else m_run = 1;
        m_lk = 1;
        m_owner = w;
      end else begin
        m_lk = 0;
        m_run = 0;
      end
      m_last = w;
    end else begin
      m_lk = 0;
      m_run = 0;
    end
    #1;
  endtask

  typedef struct {
    bit r0, r1, w0, w1, l0, l1;
    bit eg0, eg1, ev0, ev1;
  } vec_t;

  vec_t tv [22];

  task automatic new_req(input int p);
    bit on;
    bit we;
    bit lk;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    on = ($urandom_range(0, 99) < 70);
    we = 1'($urandom_range(0, 1));
    lk = ($urandom_range(0, 2) == 0);
    a  = AW'($urandom_range(0, 15));
    d  = $urandom;
    if (p == 0) begin
      req0 = on; we0 = we; lock0 = lk; addr0 = a; wdata0 = d;
    end else begin
      req1 = on; we1 = we; lock1 = lk; addr1 = a; wdata1 = d;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_arr[i] = '0;
    // r0 r1 w0 w1 l0 l1 | g0 g1 v0 v1
    tv[0]  = '{1,1,0,0,0,0, 1,0,0,0};
    tv[1]  = '{0,1,0,0,0,0, 0,1,1,0};
    tv[2]  = '{0,0,0,0,0,0, 0,0,0,1};
    tv[3]  = '{1,1,0,0,0,0, 1,0,0,0};
    tv[4]  = '{1,1,0,0,0,0, 0,1,1,0};
    tv[5]  = '{1,1,0,0,0,0, 1,0,0,1};
    tv[6]  = '{1,1,0,0,0,0, 0,1,1,0};
    tv[7]  = '{1,1,0,0,0,0, 1,0,0,1};
    tv[8]  = '{1,1,0,0,0,0, 0,1,1,0};
    tv[9]  = '{0,0,0,0,0,0, 0,0,0,1};
    tv[10] = '{0,1,1,1,0,1, 0,1,0,0};
    tv[11] = '{1,1,1,1,0,1, 0,1,0,0};
    tv[12] = '{1,1,1,1,0,1, 0,1,0,0};
    tv[13] = '{1,1,1,1,0,1, 0,1,0,0};
    tv[14] = '{1,1,1,1,0,1, 1,0,0,0};
    tv[15] = '{1,1,1,1,0,1, 0,1,0,0};
    tv[16] = '{0,0,0,0,0,0, 0,0,0,0};
    tv[17] = '{1,1,1,1,1,0, 1,0,0,0};
    tv[18] = '{1,1,1,1,1,0, 1,0,0,0};
    tv[19] = '{1,1,1,1,0,0, 1,0,0,0};
    tv[20] = '{1,1,1,1,0,0, 0,1,0,0};
    tv[21] = '{0,0,0,0,0,0, 0,0,0,0};

    rst = 1'b1;
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; lock0 = 0; lock1 = 0;
    addr0 = 10'h100; addr1 = 10'h200;
    wdata0 = 32'hA5A5_0000; wdata1 = 32'h5A5A_0000;
    model_reset();
    last_w = -1;

    // Outputs held quiet in reset even with requests pending
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
      chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
      chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Vector table: tie after reset, alternation, lock runs
    for (int i = 0; i < 22; i++) begin
      req0 = tv[i].r0; req1 = tv[i].r1;
      we0 = tv[i].w0; we1 = tv[i].w1;
      lock0 = tv[i].l0; lock1 = tv[i].l1;
      tick();
      chk($sformatf("tv%0d_gnt0", i), {31'd0, g0_s}, {31'd0, tv[i].eg0});
      chk($sformatf("tv%0d_gnt1", i), {31'd0, g1_s}, {31'd0, tv[i].eg1});
    end
    // rvalid columns refer to the cycle in which the vector applies;
    // verify them by replaying against the registered record below.
    begin
      // tv[i].ev* were checked implicitly by the model; repeat the
      // tie-after-reset read return here explicitly is not possible
      // post hoc, so the table rvalid columns are checked by rerun.
    end

    // Single write then read on port 0
    req1 = 0; lock0 = 0; lock1 = 0;
    req0 = 1; we0 = 1; addr0 = 10'h005; wdata0 = 32'hDEAD_BEEF;
    tick();
    chk("wr5_gnt0", {31'd0, g0_s}, 32'd1);
    chk("wr5_gnt1", {31'd0, g1_s}, 32'd0);
    we0 = 0;
    tick();
    chk("rd5_gnt0", {31'd0, g0_s}, 32'd1);
    chk("rd5_gnt1", {31'd0, g1_s}, 32'd0);
    chk("rd5_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("rd5_rdata0", rdata0, 32'hDEAD_BEEF);
    req0 = 0;
    tick();
    chk("rd5_rvalid0_drop", {31'd0, rvalid0}, 32'd0);

    // Reset during a granted write; a pending read is dropped too
    req0 = 1; we0 = 1; addr0 = 10'h00A; wdata0 = 32'h1111_1111;
    tick();
    we0 = 0;
    tick();
    we0 = 1; wdata0 = 32'h1234_5678;
    @(negedge clk);
    chk("rw_gnt0_pre", {31'd0, gnt0}, 32'd1);
    chk("rw_rvalid0_pre", {31'd0, rvalid0}, 32'd1);
    chk("rw_mem_we_pre", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rw_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rw_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rw_rvalid0", {31'd0, rvalid0}, 32'd0);
    @(posedge clk); #1;
    chk("rw_rvalid0_edge", {31'd0, rvalid0}, 32'd0);
    chk("rw_mem_we_edge", {31'd0, mem_we}, 32'd0);
    req0 = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    tick();
    chk("rw_rvalid0_after", {31'd0, rvalid0}, 32'd0);
    req0 = 1; we0 = 0; addr0 = 10'h00A;
    tick();
    chk("rw_read_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("rw_read_rdata0", rdata0, 32'h1111_1111);
    req0 = 0;
    tick();

    // Randomized traffic with hold-until-granted requesters
    new_req(0);
    new_req(1);
    for (int c = 0; c < 400; c++) begin
      tick();
      if (!req0 || last_w == 0) new_req(0);
      if (!req1 || last_w == 1) new_req(1);
    end
    req0 = 0; req1 = 0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Registered read-valid against the table's expectation for the
  // cycle each vector was applied in, sampled on the falling edge.
  int tv_idx = -1;
  always @(negedge clk) begin
    if (!rst && tv_idx >= 0 && tv_idx < 22) begin
      chk($sformatf("tv%0d_rvalid0", tv_idx), {31'd0, rvalid0},
          {31'd0, tv[tv_idx].ev0});
      chk($sformatf("tv%0d_rvalid1", tv_idx), {31'd0, rvalid1},
          {31'd0, tv[tv_idx].ev1});
    end
  end

  // tv_idx follows the vector currently on the inputs: the table
  // starts at the first rising edge after reset release.
  initial begin
    @(negedge rst);
    for (int i = 0; i < 22; i++) begin
      tv_idx = i;
      @(posedge clk);
    end
    tv_idx = -1;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port 4 KB word memory between the multicycle CPU data path (port 0) and the program loader / debug port (port 1). Grants at most one access per cycle with round-robin fairness, supports a bounded lock for atomic read-modify-write sequences, and returns read data one cycle after grant. Sits between the requesters and the memory array. The memory uses a synchronous read and a synchronous write.

## Interface
- AW, 10, word-address width, matching addr[11:2].
- DW, 32, data width.
- LOCK_MAX, 4, maximum consecutive locked grants honoured while the other port is requesting; must be ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1  access request; held, with its qualifiers, until granted.
- we0, we1  in  1  1 = write, 0 = read.
- lock0, lock1  in  1  requests that the grant be kept on this port's next access.
- addr0, addr1  in  AW  word address.
- wdata0, wdata1  in  DW  write data.
- gnt0, gnt1  out  1  grant; combinational. The access completes at the rising edge where gnt=1.
- rvalid0, rvalid1  out  1  registered; read data valid this cycle.
- rdata0, rdata1  out  DW  equal to mem_dout; meaningful only while the matching rvalid is 1.
- mem_addr  out  AW  to memory.
- mem_din  out  DW  to memory.
- mem_we  out  1  to memory.
- mem_dout  in  DW  memory read data, valid the cycle after the address is presented.

## Operation
**State registers**
- last_grant: 1 bit, resets to 1 so port 0 wins the first tie.
- locked: 1 bit, reset 0.
- lock_owner: 1 bit, reset 0.
- lock_cnt: $clog2(LOCK_MAX+1) bits, reset 0.
- rvalid0, rvalid1: reset 0.

**Arbitration, evaluated each cycle**
- No requests: no grant; mem_we=0; mem_addr/mem_din hold the port-0 values (don't-care).
- One request: that port is granted.
- Both request, locked=1, and lock_cnt<LOCK_MAX: lock_owner is granted.
- Both request otherwise: the port ≠ last_grant is granted.
- Exactly one gnt is high when any req is high. gnt is never high without its req.

**Memory mux**
- mem_addr, mem_din and mem_we are taken from the granted port.
- mem_we = we_g & gnt_g.

**Edge updates when port g is granted**
- last_grant ← g.
- If lock_g=1:
  - If locked=1 and lock_owner=g: lock_cnt ← lock_cnt+1, saturating at LOCK_MAX.
  - Otherwise: lock_cnt ← 1.
  - In both cases: locked ← 1, lock_owner ← g.
- If lock_g=0: locked ← 0, lock_cnt ← 0.

**Edge updates on other cycles**
- Idle cycle: locked ← 0, lock_cnt ← 0.
- Lock expiry: when a grant goes to the non-owner because lock_cnt=LOCK_MAX, that port's own lock bit sets the new state per the rules above.

**Read return**
- rvalid_g ← gnt_g & ~we_g.
- rdata is passed straight through from mem_dout.

## Timing
- Grant latency is 0 cycles: gnt is valid in the same cycle as req, provided the port wins arbitration.
- Write latency: memory is updated at the granting edge.
- Read latency: rvalid is high, with data, exactly 1 cycle after the granting edge.
- Throughput: 1 access/cycle aggregate. Back-to-back grants to the same port are allowed when the other port is idle.
- Under continuous contention without lock, ports alternate every cycle.
- With lock held continuously under contention, the owner gets LOCK_MAX consecutive grants; the next grant goes to the other port.
- A requester must keep req, we, addr and wdata stable until it sees gnt=1 at an edge. Changing them before then is illegal.

**Reset**
- While rst=1: gnt0=gnt1=0, mem_we=0, rvalid0=rvalid1=0.
- Reset asserted mid-access: a write in that cycle is suppressed; a pending read's rvalid is cleared and is not issued after reset release.
- The first cycle after release follows the normal rules from reset state.

## Test plan
- **Single write/read on port 0:** req0 write addr=0x005 data=0xDEADBEEF, then a read of 0x005. Required: gnt0 high in both cycles; rvalid0=1 with rdata0=0xDEADBEEF exactly one cycle after the read grant; gnt1=0 throughout.
- **Tie after reset:** req0 and req1 both asserted for reads in the first cycle after reset. Required: gnt0 first, then gnt1 next cycle; rvalid0 then rvalid1 on consecutive cycles.
- **Continuous contention without lock:** both ports request continuously for 6 cycles. Required: grant order 0,1,0,1,0,1; no cycle has both grants high.
- **Lock under contention, LOCK_MAX=4:** port 1 holds lock1=1 while port 0 requests. Required: gnt1 for 4 consecutive cycles, then gnt0; lock_cnt resets when ownership changes.
- **Lock released:** port 0 asserts lock for 2 cycles, then drops it while port 1 requests. Required: port 1 is granted on the cycle immediately after the first unlocked port-0 grant.
- **Reset mid-write:** rst asserted during a granted write of 0x12345678 to addr 0x00A. Required: mem_we=0 and all gnt/rvalid=0 while rst=1; a subsequent read of 0x00A returns the prior contents.
